l1d_mem_unit: RTL and testbench
===============================

# l1d_mem_unit

Parametrised, multi-port L1 data memory unit; successor to the fixed two-port, 16-bit data cache. It sits between the execute-stage issue ports and the register-file writeback ports, serving N independent load/store channels from one shared data array. Compared with the previous generation it adds configurable width, depth and channel count; self-clearing initialisation after reset; deterministic same-cycle conflict resolution; and an out-of-range address fault per channel.

## Interface
- NUM_PORTS, 2, number of independent load/store channels
- DATA_WIDTH, 16, data, operand and address operand width
- DEPTH, 1024, data array entries; legal addresses are 0..DEPTH-1
- WB_ADDR_WIDTH, 5, register-file writeback address width
- clock_i  in  1  single clock; all state on rising edge
- reset_n_i  in  1  reset, asynchronous, active-low
- valid_i  in  NUM_PORTS  per-channel request strobe (load/store enable)
- isWb_i  in  NUM_PORTS  request wants register writeback
- wbAddress_i  in  NUM_PORTS*WB_ADDR_WIDTH  destination register, channel p at [p*W +: W]
- opCode_i  in  NUM_PORTS*7  opcode per channel
- pOperand_i, sOperand_i  in  NUM_PORTS*DATA_WIDTH  store data / address-or-immediate
- ready_o  out  1  unit accepts requests
- wbEnable_o  out  NUM_PORTS  writeback strobe per channel
- wbAddress_o  out  NUM_PORTS*WB_ADDR_WIDTH  writeback register
- wbData_o  out  NUM_PORTS*DATA_WIDTH  writeback data
- fault_o  out  NUM_PORTS  one-cycle pulse: LOAD/STORE address >= DEPTH

## Operation
- Opcodes: 0 NOP; 10 MOVI (wbData = sOperand); 11 LOAD (wbData = mem[sOperand]); 12 STORE (mem[sOperand] <= pOperand, no writeback). All other opcodes behave as NOP.
- wbEnable = isWb for MOVI/LOAD; 0 for NOP, STORE, illegal opcode, fault.
- Fault: LOAD or STORE with sOperand >= DEPTH leaves memory unchanged and produces wbData 0, wbEnable 0, fault 1. MOVI never faults.
- Invalid channel in a cycle (valid 0 or ready_o 0): that slot produces wbEnable 0, fault 0, wbData 0. wbAddress passes through unchanged. Outputs do not hold stale enables.
- Controller states:
  - INIT: entered on reset. Writes 0 to address clr_cnt each cycle, clr_cnt 0..DEPTH-1. ready_o=0; all requests are ignored.
  - RUN: after the write of DEPTH-1. ready_o=1.
- Same-cycle conflicts, resolved in execute:
  - Several STOREs to one address: highest channel index wins.
  - LOAD and STORE to one address: LOAD returns the pre-store value.
- A LOAD executing one cycle after a STORE to the same address returns the new value.

## Timing
- Reset (asynchronous assert): ready_o=0, wbEnable_o=0, fault_o=0, wbData_o=0, wbAddress_o=0; pipeline valids cleared; clr_cnt=0; state INIT.
- Reset asserted mid-INIT or mid-RUN aborts everything in flight. The clear restarts from address 0.
- INIT length: ready_o rises at the DEPTH-th rising edge after reset_n_i deasserts.
- Pipeline per channel, no backpressure, one request per channel per cycle:
  - Edge E0: inputs captured if ready_o=1 before E0.
  - Edge E1: execute — array read/write, result registered.
  - Edge E2: outputs registered; visible after E2.
- Latency 2 cycles, full throughput on every channel.
- Array writes occur at E1. A request captured at E0+1 reads data written at E1.
- fault_o is a single-cycle pulse aligned with the wbData_o slot of the faulting request.

## Test plan
- Reset/init (DEPTH=16): release reset -> ready_o low 15 edges, high after 16th; LOAD addr 7 on ch0 -> wbData 0x0000, wbEnable 1 at E2.
- Basic ops: ch0 STORE p=0xBEEF s=5, next cycle ch1 LOAD s=5 isWb=1 wbAddr=3 -> ch1 wbEnable 1, wbAddress 3, wbData 0xBEEF; ch0 MOVI s=0x1234 -> wbData 0x1234.
- Conflicts, same cycle:
  - ch0 STORE 0x1111 and ch1 STORE 0x2222 to addr 9, then LOAD 9 -> 0x2222.
  - ch0 LOAD 9 with ch1 STORE 0x3333 to 9 -> ch0 gets 0x2222; a later LOAD gets 0x3333.
- Fault: LOAD s=16 and STORE s=20 (DEPTH=16) -> fault_o pulse 1 cycle on those channels, wbEnable 0, wbData 0, array unchanged (re-read addr 4 = prior value).
- Throughput/invalid: back-to-back MOVI 1,2,3 on all channels every cycle -> outputs 1,2,3 on consecutive cycles. A valid=0 gap -> wbEnable 0 that cycle. Opcode 0x55 -> treated as NOP.
- Reset mid-run: assert reset_n_i with LOADs in flight -> outputs 0 immediately, ready_o 0. After release, no stale writeback; memory re-cleared (LOAD 5 -> 0x0000).

Source files
------------

// File: rtl/l1d_mem_unit.sv
// l1d_mem_unit: multi-channel L1 data memory with a shared array.
// Each channel has a three-register pipeline: capture, execute (array access), output.
// After reset the array is cleared one entry per cycle before requests are accepted.
module l1d_mem_unit #(
  parameter int NUM_PORTS     = 2,
  parameter int DATA_WIDTH    = 16,
  parameter int DEPTH         = 1024,
  parameter int WB_ADDR_WIDTH = 5
) (
  input  logic                                clock_i,
  input  logic                                reset_n_i,
  input  logic [NUM_PORTS-1:0]                valid_i,
  input  logic [NUM_PORTS-1:0]                isWb_i,
  input  logic [NUM_PORTS*WB_ADDR_WIDTH-1:0]  wbAddress_i,
  input  logic [NUM_PORTS*7-1:0]              opCode_i,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]     pOperand_i,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]     sOperand_i,
  output logic                                ready_o,
  output logic [NUM_PORTS-1:0]                wbEnable_o,
  output logic [NUM_PORTS*WB_ADDR_WIDTH-1:0]  wbAddress_o,
  output logic [NUM_PORTS*DATA_WIDTH-1:0]     wbData_o,
  output logic [NUM_PORTS-1:0]                fault_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [DATA_WIDTH:0] LP_DEPTH_X = (DATA_WIDTH+1)'(DEPTH);

  localparam logic [6:0] OP_MOVI  = 7'd10;
  localparam logic [6:0] OP_LOAD  = 7'd11;
  localparam logic [6:0] OP_STORE = 7'd12;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t           r_state;
  logic             r_ready;
  logic [AW-1:0]    r_clr_cnt;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  // capture stage
  logic [NUM_PORTS-1:0]               r_s1_valid;
  logic [NUM_PORTS-1:0]               r_s1_wb;
  logic [NUM_PORTS*WB_ADDR_WIDTH-1:0] r_s1_wbaddr;
  logic [NUM_PORTS*7-1:0]             r_s1_op;
  logic [NUM_PORTS*DATA_WIDTH-1:0]    r_s1_pop;
  logic [NUM_PORTS*DATA_WIDTH-1:0]    r_s1_sop;

  // execute stage
  logic [NUM_PORTS-1:0]               r_s2_en;
  logic [NUM_PORTS-1:0]               r_s2_fault;
  logic [NUM_PORTS*WB_ADDR_WIDTH-1:0] r_s2_wbaddr;
  logic [NUM_PORTS*DATA_WIDTH-1:0]    r_s2_data;

  logic [NUM_PORTS-1:0]               w_fault;
  logic [NUM_PORTS-1:0]               w_en;
  logic [NUM_PORTS-1:0]               w_we;
  logic [NUM_PORTS*DATA_WIDTH-1:0]    w_data;
  logic [NUM_PORTS*AW-1:0]            w_addr;

  assign ready_o = r_ready;

  // Controller: sweep the clear counter through the array, then run.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state   <= ST_INIT;
      r_clr_cnt <= '0;
      r_ready   <= 1'b0;
    end else begin
      case (r_state)
        ST_INIT: begin
          if (r_clr_cnt == AW'(DEPTH-1)) begin
            r_state <= ST_RUN;
            r_ready <= 1'b1;
          end else begin
            r_clr_cnt <= r_clr_cnt + AW'(1);
          end
        end
        default: r_ready <= 1'b1;
      endcase
    end
  end

  // Execute decode: array reads see the value before this edge's writes.
  always_comb begin
    w_fault = '0;
    w_en    = '0;
    w_we    = '0;
    w_data  = '0;
    w_addr  = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      w_addr[p*AW +: AW] = r_s1_sop[p*DATA_WIDTH +: AW];
      if (r_s1_valid[p]) begin
        case (r_s1_op[p*7 +: 7])
          OP_MOVI: begin
            w_en[p] = r_s1_wb[p];
            w_data[p*DATA_WIDTH +: DATA_WIDTH] = r_s1_sop[p*DATA_WIDTH +: DATA_WIDTH];
          end
          OP_LOAD: begin
            if ({1'b0, r_s1_sop[p*DATA_WIDTH +: DATA_WIDTH]} >= LP_DEPTH_X) begin
              w_fault[p] = 1'b1;
            end else begin
              w_en[p] = r_s1_wb[p];
              w_data[p*DATA_WIDTH +: DATA_WIDTH] = r_mem[w_addr[p*AW +: AW]];
            end
          end
          OP_STORE: begin
            if ({1'b0, r_s1_sop[p*DATA_WIDTH +: DATA_WIDTH]} >= LP_DEPTH_X) begin
              w_fault[p] = 1'b1;
            end else begin
              w_we[p] = 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Array writes: clear sweep during init, otherwise stores (highest channel wins).
  always_ff @(posedge clock_i) begin
    if (r_state == ST_INIT) begin
      r_mem[r_clr_cnt] <= '0;
    end else begin
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
        if (w_we[p]) begin
          r_mem[w_addr[p*AW +: AW]] <= r_s1_pop[p*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  // Per-channel pipeline: capture, execute result, output registers.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_s1_valid  <= '0;
      r_s1_wb     <= '0;
      r_s1_wbaddr <= '0;
      r_s1_op     <= '0;
      r_s1_pop    <= '0;
      r_s1_sop    <= '0;
      r_s2_en     <= '0;
      r_s2_fault  <= '0;
      r_s2_wbaddr <= '0;
      r_s2_data   <= '0;
      wbEnable_o  <= '0;
      fault_o     <= '0;
      wbAddress_o <= '0;
      wbData_o    <= '0;
    end else begin
      r_s1_valid  <= valid_i & {NUM_PORTS{r_ready}};
      r_s1_wb     <= isWb_i;
      r_s1_wbaddr <= wbAddress_i;
      r_s1_op     <= opCode_i;
      r_s1_pop    <= pOperand_i;
      r_s1_sop    <= sOperand_i;

      r_s2_en     <= w_en;
      r_s2_fault  <= w_fault;
      r_s2_wbaddr <= r_s1_wbaddr;
      r_s2_data   <= w_data;

      wbEnable_o  <= r_s2_en;
      fault_o     <= r_s2_fault;
      wbAddress_o <= r_s2_wbaddr;
      wbData_o    <= r_s2_data;
    end
  end

endmodule

// File: tb/tb_l1d_mem_unit.sv
// Directed bench for l1d_mem_unit with DEPTH=16, two channels.
module tb_l1d_mem_unit;
  localparam int NP = 2;
  localparam int DW = 16;
  localparam int WA = 5;
  localparam int DEPTH = 16;

  localparam logic [6:0] OP_MOVI  = 7'd10;
  localparam logic [6:0] OP_LOAD  = 7'd11;
  localparam logic [6:0] OP_STORE = 7'd12;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NP-1:0]     valid;
  logic [NP-1:0]     iswb;
  logic [NP*WA-1:0]  wbaddr_in;
  logic [NP*7-1:0]   op;
  logic [NP*DW-1:0]  pop;
  logic [NP*DW-1:0]  sop;
  logic              ready;
  logic [NP-1:0]     wb_en;
  logic [NP*WA-1:0]  wb_addr;
  logic [NP*DW-1:0]  wb_data;
  logic [NP-1:0]     fault;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  l1d_mem_unit #(
    .NUM_PORTS(NP),
    .DATA_WIDTH(DW),
    .DEPTH(DEPTH),
    .WB_ADDR_WIDTH(WA)
  ) dut (
    .clock_i(clk),
    .reset_n_i(rst_n),
    .valid_i(valid),
    .isWb_i(iswb),
    .wbAddress_i(wbaddr_in),
    .opCode_i(op),
    .pOperand_i(pop),
    .sOperand_i(sop),
    .ready_o(ready),
    .wbEnable_o(wb_en),
    .wbAddress_o(wb_addr),
    .wbData_o(wb_data),
    .fault_o(fault)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] dat(input int ch);
    return wb_data[ch*DW +: DW];
  endfunction

  function automatic logic [WA-1:0] wa(input int ch);
    return wb_addr[ch*WA +: WA];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    valid = '0; iswb = '0; wbaddr_in = '0; op = '0; pop = '0; sop = '0;
  endtask

  task automatic req(input int ch, input logic [6:0] o, input logic w,
                     input logic [WA-1:0] a, input logic [DW-1:0] p, input logic [DW-1:0] s);
    valid[ch] = 1'b1;
    iswb[ch]  = w;
    wbaddr_in[ch*WA +: WA] = a;
    op[ch*7 +: 7] = o;
    pop[ch*DW +: DW] = p;
    sop[ch*DW +: DW] = s;
  endtask

  // issue edge, then two more edges: the request's result is on the outputs
  task automatic run3();
    tick(); clr(); tick(); tick();
  endtask

  task automatic init_seq(input string tag);
    for (int i = 1; i <= DEPTH; i++) begin
      tick();
      check({tag, "_en"}, 32'(wb_en), 32'h0);
      if (i < DEPTH) check({tag, "_rdy_lo"}, 32'(ready), 32'h0);
    end
    check({tag, "_rdy_hi"}, 32'(ready), 32'h1);
  endtask

  initial begin
    clr();
    rst_n = 1'b0;
    #12;
    check("rst_ready", 32'(ready), 32'h0);
    check("rst_en", 32'(wb_en), 32'h0);
    check("rst_fault", 32'(fault), 32'h0);
    check("rst_data", wb_data, 32'h0);
    check("rst_wbaddr", 32'(wb_addr), 32'h0);
    tick();
    rst_n = 1'b1;
    init_seq("init");

    // freshly cleared entry
    req(0, OP_LOAD, 1'b1, 5'd2, 16'h0, 16'd7);
    run3();
    check("init_ld_en", 32'(wb_en), 32'h1);
    check("init_ld_data", 32'(dat(0)), 32'h0);
    check("init_ld_addr", 32'(wa(0)), 32'h2);

    // store then load next cycle on another channel, plus MOVI
    req(0, OP_STORE, 1'b1, 5'd0, 16'hBEEF, 16'd5);
    tick(); clr();
    req(0, OP_MOVI, 1'b1, 5'd1, 16'h0, 16'h1234);
    req(1, OP_LOAD, 1'b1, 5'd3, 16'h0, 16'd5);
    tick(); clr();
    tick();
    check("st_no_wb", 32'(wb_en), 32'h0);
    tick();
    check("basic_en", 32'(wb_en), 32'h3);
    check("basic_ld_data", 32'(dat(1)), 32'hBEEF);
    check("basic_ld_addr", 32'(wa(1)), 32'h3);
    check("basic_movi", 32'(dat(0)), 32'h1234);
    check("basic_movi_addr", 32'(wa(0)), 32'h1);

    // two stores to one address: higher channel wins
    req(0, OP_STORE, 1'b0, 5'd0, 16'h1111, 16'd9);
    req(1, OP_STORE, 1'b0, 5'd0, 16'h2222, 16'd9);
    run3();
    req(0, OP_LOAD, 1'b1, 5'd4, 16'h0, 16'd9);
    run3();
    check("ww_conflict", 32'(dat(0)), 32'h2222);

    // load and store to one address: load sees old value
    req(0, OP_LOAD, 1'b1, 5'd4, 16'h0, 16'd9);
    req(1, OP_STORE, 1'b1, 5'd0, 16'h3333, 16'd9);
    run3();
    check("rw_conflict", 32'(dat(0)), 32'h2222);
    check("rw_en", 32'(wb_en), 32'h1);
    req(1, OP_LOAD, 1'b1, 5'd6, 16'h0, 16'd9);
    run3();
    check("rw_after", 32'(dat(1)), 32'h3333);

    // out-of-range faults; s=20 aliases addr 4 in the low bits
    req(0, OP_STORE, 1'b0, 5'd0, 16'h4444, 16'd4);
    run3();
    req(0, OP_LOAD, 1'b1, 5'd7, 16'h0, 16'd16);
    req(1, OP_STORE, 1'b1, 5'd0, 16'hDEAD, 16'd20);
    run3();
    check("flt_pulse", 32'(fault), 32'h3);
    check("flt_en", 32'(wb_en), 32'h0);
    check("flt_data", wb_data, 32'h0);
    tick();
    check("flt_single", 32'(fault), 32'h0);
    req(0, OP_LOAD, 1'b1, 5'd7, 16'h0, 16'd4);
    req(1, OP_MOVI, 1'b1, 5'd8, 16'h0, 16'hFFFF);
    run3();
    check("flt_mem_intact", 32'(dat(0)), 32'h4444);
    check("movi_no_fault", 32'(fault), 32'h0);
    check("movi_big", 32'(dat(1)), 32'hFFFF);
    req(0, OP_LOAD, 1'b1, 5'd1, 16'h0, 16'd15);
    run3();
    check("last_addr_fault", 32'(fault), 32'h0);
    check("last_addr_en", 32'(wb_en), 32'h1);
    check("last_addr_data", 32'(dat(0)), 32'h0);

    // back-to-back MOVI, then a gap, then an illegal opcode
    for (int k = 1; k <= 3; k++) begin
      req(0, OP_MOVI, 1'b1, WA'(k), 16'h0, DW'(k));
      req(1, OP_MOVI, 1'b1, WA'(k + 8), 16'h0, DW'(k + 16));
      tick();
    end
    clr();
    check("tp1_en", 32'(wb_en), 32'h3);
    check("tp1_d0", 32'(dat(0)), 32'h1);
    check("tp1_d1", 32'(dat(1)), 32'h11);
    tick();
    req(0, 7'h55, 1'b1, 5'd12, 16'h0, 16'h0077);
    req(1, 7'h55, 1'b1, 5'd13, 16'h0, 16'h0088);
    check("tp2_d0", 32'(dat(0)), 32'h2);
    check("tp2_d1", 32'(dat(1)), 32'h12);
    check("tp2_a1", 32'(wa(1)), 32'hA);
    tick(); clr();
    check("tp3_d0", 32'(dat(0)), 32'h3);
    check("tp3_en", 32'(wb_en), 32'h3);
    tick();
    check("gap_en", 32'(wb_en), 32'h0);
    check("gap_data", wb_data, 32'h0);
    tick();
    check("illop_en", 32'(wb_en), 32'h0);
    check("illop_data", wb_data, 32'h0);
    check("illop_fault", 32'(fault), 32'h0);
    check("illop_addr", 32'(wa(1)), 32'hD);

    // reset with loads in flight
    req(0, OP_LOAD, 1'b1, 5'd9, 16'h0, 16'd5);
    tick();
    req(0, OP_LOAD, 1'b1, 5'd9, 16'h0, 16'd5);
    tick(); clr();
    tick();
    check("pre_rst_data", 32'(dat(0)), 32'hBEEF);
    check("pre_rst_en", 32'(wb_en), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_en", 32'(wb_en), 32'h0);
    check("mid_rst_data", wb_data, 32'h0);
    check("mid_rst_ready", 32'(ready), 32'h0);
    check("mid_rst_addr", 32'(wb_addr), 32'h0);
    tick(); tick();
    rst_n = 1'b1;
    init_seq("reinit");
    req(0, OP_LOAD, 1'b1, 5'd2, 16'h0, 16'd5);
    run3();
    check("recleared_en", 32'(wb_en), 32'h1);
    check("recleared_data", 32'(dat(0)), 32'h0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
